// File: rtl/c_registers_irq.sv
// c_registers_irq: ZKTC control registers (PC/SP/PSR/TR/PPC/PPSR/IPR) with maskable IRQs; CREG_TIMER_IRQ_EN adds a timer-wrap source at pend bit NIRQ
module c_registers_irq #(
    parameter int XLEN = 16,
    parameter int NIRQ = 4,
    parameter logic [XLEN-1:0] PC_INIT = 16'hB000,
    parameter logic [XLEN-1:0] PC_EXC = 16'h0000,
    parameter logic [XLEN-1:0] PC_IRQ = 16'h0004,
`ifdef CREG_TIMER_IRQ_EN
    localparam int NSRC = NIRQ + 1,
`else
    localparam int NSRC = NIRQ,
`endif
    localparam int CW = (NSRC > 8) ? 4 : 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ill_inst,
    input  logic            trap,
    input  logic            rfi,
    input  logic [NIRQ-1:0] irq,
    input  logic [2:0]      raddr,
    output logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] psr_out,
    input  logic            wen,
    input  logic [2:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic            pc_wen,
    input  logic [XLEN-1:0] next_pc,
    input  logic            tr_wen,
    input  logic            tr_ren,
    output logic            irq_taken,
    output logic [CW-1:0]   irq_cause
);
    logic [XLEN-1:0] pc, sp, psr, tlr, thr, ppc, ppsr;
    logic [2*XLEN-1:0] tr;
    logic [NIRQ-1:0] s1, s2, prev;
    logic [NSRC-1:0] pend, elig, rise, w1c, clr;
    logic [CW-1:0] k;
    logic take;

    assign pc_out = pc;
    assign psr_out = psr;
    assign elig = pend & psr[4 +: NSRC] & {NSRC{psr[3]}};
    assign take = pc_wen & |elig & ~ill_inst & ~trap & ~rfi;
`ifdef CREG_TIMER_IRQ_EN
    assign rise = {&tr & ~tr_wen, s2 & ~prev};
`else
    assign rise = s2 & ~prev;
`endif
    assign w1c = (wen && waddr == 3'd7) ? wdata[NSRC-1:0] : '0;
    assign clr = take ? NSRC'(1) << k : '0;

    // lowest-index eligible source wins
    always_comb begin
        k = '0;
        for (int i = NSRC - 1; i >= 0; i--) if (elig[i]) k = CW'(i);
    end

    // combinational CSR read port
    always_comb begin
        case (raddr)
            3'd1: rdata = sp;
            3'd2: rdata = psr;
            3'd3: rdata = tlr;
            3'd4: rdata = thr;
            3'd5: rdata = ppc;
            3'd6: rdata = ppsr;
            3'd7: rdata = XLEN'(pend);
            default: rdata = '0;
        endcase
    end

    // irq synchroniser, edge detect and pending bits (a new edge beats W1C and entry clear)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
            prev <= '0;
            pend <= '0;
        end else begin
            s1 <= irq;
            s2 <= s1;
            prev <= s2;
            pend <= (pend & ~w1c & ~clr) | rise;
        end
    end

    // timer, CSR writes and control-flow events; later assignments carry higher priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= PC_INIT;
            sp <= '0;
            psr <= '0;
            tlr <= '0;
            thr <= '0;
            ppc <= '0;
            ppsr <= '0;
            tr <= '0;
        end else begin
            tr <= tr_wen ? {thr, tlr} : tr + 1'b1;
            if (tr_ren) tlr <= tr[XLEN-1:0];
            if (tr_ren) thr <= tr[2*XLEN-1:XLEN];
            if (wen) begin
                case (waddr)
                    3'd1: sp <= wdata;
                    3'd2: psr <= wdata;
                    3'd3: tlr <= wdata;
                    3'd4: thr <= wdata;
                    3'd5: ppc <= wdata;
                    3'd6: ppsr <= wdata;
                    default: ;
                endcase
            end
            if (ill_inst || trap) begin
                pc <= PC_EXC;
                ppc <= pc + XLEN'(2);
                ppsr <= psr;
                psr <= XLEN'(ill_inst ? 3'b011 : 3'b101);
            end else if (take) begin
                pc <= PC_IRQ;
                ppc <= next_pc;
                ppsr <= psr;
                psr <= XLEN'(3'b111);
            end else if (rfi) begin
                pc <= ppc;
                psr <= ppsr;
            end else if (pc_wen) begin
                pc <= next_pc;
            end
        end
    end

    // registered interrupt-entry pulse and cause
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_taken <= 1'b0;
            irq_cause <= '0;
        end else begin
            irq_taken <= take;
            irq_cause <= take ? k : '0;
        end
    end
endmodule
